// File: rtl/fp_pkg.sv
// Shared definitions for the fpAdder sequencing logic and its benches.
package fp_pkg;

  localparam int FP_WIDTH = 32;

  localparam logic [FP_WIDTH-1:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [FP_WIDTH-1:0] FP_NEG_INF = 32'hFF80_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPT,
    OUT
  } seq_state_t;

endpackage

// File: rtl/fp_operand_fifo.sv
// Synchronous operand-pair FIFO; pointers carry one extra wrap bit for full/empty.
module fp_operand_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + 1'b1;
      end
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);

endmodule

// File: rtl/fp_add_sequencer.sv
// Front/back end for the multi-cycle fpAdder: operand FIFO in, setup/hold
// sequencing of enable/in1/in2, and a held result on a valid/ready stream.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting; pops FIFO head into add_in1/add_in2 when non-empty
//   LOAD  | operands stable, enable low (adder setup cycle), clear counter
//   RUN   | enable high, counting ADD_LATENCY cycles
//   CAPT  | enable high for final cycle, sample add_out/add_overflow
//   OUT   | result presented, held until res_ready
module fp_add_sequencer
  import fp_pkg::*;
#(
  parameter int WIDTH       = FP_WIDTH,
  parameter int DEPTH       = 4,
  parameter int ADD_LATENCY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             add_enable,
  output logic [WIDTH-1:0] add_in1,
  output logic [WIDTH-1:0] add_in2,
  input  logic [WIDTH-1:0] add_out,
  input  logic             add_overflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_overflow,
  output logic             ovf_sticky,
  output logic             busy
);

  localparam int CW = $clog2(ADD_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ADD_LATENCY - 1);

  seq_state_t         state_q;
  seq_state_t         state_d;
  logic [CW-1:0]      cnt;
  logic               pop;
  logic               full;
  logic               empty;
  logic [2*WIDTH-1:0] head;

  fp_operand_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .wdata ({in_a, in_b}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = LOAD;
      end
      LOAD:    state_d = RUN;
      RUN:     if (cnt == CNT_LAST) state_d = CAPT;
      CAPT:    state_d = OUT;
      OUT:     if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands only load on the IDLE pop, so they cannot move while enable is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_in1      <= '0;
      add_in2      <= '0;
      cnt          <= '0;
      res_data     <= '0;
      res_overflow <= 1'b0;
      ovf_sticky   <= 1'b0;
    end else begin
      if (pop) begin
        add_in1 <= head[2*WIDTH-1:WIDTH];
        add_in2 <= head[WIDTH-1:0];
      end
      if (state_q == LOAD)     cnt <= '0;
      else if (state_q == RUN) cnt <= cnt + 1'b1;
      if (state_q == CAPT) begin
        res_data     <= add_out;
        res_overflow <= add_overflow;
        ovf_sticky   <= ovf_sticky | add_overflow;
      end
    end
  end

  assign in_ready   = !full;
  assign add_enable = (state_q == RUN) || (state_q == CAPT);
  assign res_valid  = (state_q == OUT);
  assign busy       = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer with a behavioural fpAdder that only
// shows the true sum once enable has been high for the full latency.
module tb_fp_add_sequencer;
  import fp_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 4;
  localparam int NV  = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         add_enable;
  logic [W-1:0] add_in1;
  logic [W-1:0] add_in2;
  logic [W-1:0] add_out;
  logic         add_overflow;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         res_overflow;
  logic         ovf_sticky;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         ovf;
  } vec_t;

  vec_t vecs [NV];

  fp_add_sequencer #(
    .WIDTH       (W),
    .DEPTH       (4),
    .ADD_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .add_enable   (add_enable),
    .add_in1      (add_in1),
    .add_in2      (add_in2),
    .add_out      (add_out),
    .add_overflow (add_overflow),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_overflow (res_overflow),
    .ovf_sticky   (ovf_sticky),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Adder model: garbage (with overflow set) until enable has been high LAT edges.
  int en_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) en_cnt <= 0;
    else        en_cnt <= add_enable ? en_cnt + 1 : 0;
  end

  always_comb begin
    add_out      = 32'hDEAD_BEEF;
    add_overflow = 1'b1;
    if (en_cnt >= LAT) begin
      add_out      = 32'h0BAD_0BAD;
      add_overflow = 1'b0;
      for (int i = 0; i < NV; i++) begin
        if (vecs[i].a == add_in1 && vecs[i].b == add_in2) begin
          add_out      = vecs[i].sum;
          add_overflow = vecs[i].ovf;
        end
      end
    end
  end

  // Operand hold monitor and enable-cycle counter.
  int           en_cycles = 0;
  logic         en_prev = 1'b0;
  logic [W-1:0] p1, p2;
  always @(negedge clk) begin
    if (add_enable) en_cycles++;
    if (add_enable && en_prev) begin
      checks++;
      if (add_in1 !== p1 || add_in2 !== p2) begin
        errors++;
        $display("FAIL operand_hold: in1/in2 %h/%h changed from %h/%h while enable high",
                 add_in1, add_in2, p1, p2);
      end
    end
    en_prev = add_enable && reset;
    p1      = add_in1;
    p2      = add_in2;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int           edges;
  int           got;
  int           t;
  int           seen_t [2];
  logic [W-1:0] seen_d [2];
  logic         acc [NV];
  logic         sticky_exp;
  logic [W-1:0] held;
  int           stale;

  initial begin
    vecs[0] = '{32'h3FC0_0000, 32'hC0B0_0000, 32'hC080_0000, 1'b0};
    vecs[1] = '{FP_POS_INF,    32'h3F80_0000, FP_POS_INF,    1'b1};
    vecs[2] = '{32'h3FA0_0000, 32'h4020_0000, 32'h4070_0000, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h3F99_999A, 32'h3F99_999A, 1'b0};
    vecs[4] = '{32'hBFA0_0000, 32'hC020_0000, 32'hC070_0000, 1'b0};
    vecs[5] = '{FP_NEG_INF,    32'hBF80_0000, FP_NEG_INF,    1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",     32'(in_ready),     32'd1);
    chk("rst_add_enable",   32'(add_enable),   32'd0);
    chk("rst_add_in1",      add_in1,           32'd0);
    chk("rst_add_in2",      add_in2,           32'd0);
    chk("rst_res_valid",    32'(res_valid),    32'd0);
    chk("rst_res_data",     res_data,          32'd0);
    chk("rst_res_overflow", 32'(res_overflow), 32'd0);
    chk("rst_ovf_sticky",   32'(ovf_sticky),   32'd0);
    chk("rst_busy",         32'(busy),         32'd0);

    // Single operations from the table, res_ready high.
    // Latency counts rising edges from the push edge (inclusive) to res_valid.
    res_ready  = 1'b1;
    sticky_exp = 1'b0;
    for (int i = 0; i < NV; i++) begin
      en_cycles = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = vecs[i].a;
      in_b     = vecs[i].b;
      @(posedge clk);
      edges = 1;
      #1 in_valid = 1'b0;
      while (!res_valid && edges < 40) begin
        @(posedge clk);
        edges++;
        #1;
      end
      sticky_exp = sticky_exp | vecs[i].ovf;
      chk($sformatf("v%0d_latency", i),  32'(edges),        32'd8);
      chk($sformatf("v%0d_data", i),     res_data,          vecs[i].sum);
      chk($sformatf("v%0d_ovf", i),      32'(res_overflow), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_sticky", i),   32'(ovf_sticky),   32'(sticky_exp));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_en_cycles", i), 32'(en_cycles), 32'd5);
      chk($sformatf("v%0d_valid_drop", i), 32'(res_valid), 32'd0);
    end

    // Back-to-back pair: order and one result per ADD_LATENCY+4 cycles
    @(negedge clk);
    in_valid = 1'b1;
    in_a = vecs[3].a; in_b = vecs[3].b;
    @(posedge clk);
    #1 in_a = vecs[4].a; in_b = vecs[4].b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    got = 0;
    t = 2;
    while (got < 2 && t < 60) begin
      if (res_valid) begin
        seen_t[got] = t;
        seen_d[got] = res_data;
        got++;
      end
      @(posedge clk);
      t++;
      #1;
    end
    chk("b2b_count",  32'(got),                   32'd2);
    chk("b2b_first",  seen_d[0],                  vecs[3].sum);
    chk("b2b_second", seen_d[1],                  vecs[4].sum);
    chk("b2b_gap",    32'(seen_t[1] - seen_t[0]), 32'd8);

    // Backpressure: one op in flight plus four queued, sixth push refused
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < NV; j++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = vecs[j].a;
      in_b     = vecs[j].b;
      acc[j]   = in_ready;
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < NV; j++)
      chk($sformatf("bp_accept%0d", j), 32'(acc[j]), (j < 5) ? 32'd1 : 32'd0);
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    edges = 0;
    while (!res_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    held = res_data;
    repeat (5) @(negedge clk);
    chk("bp_hold_valid", 32'(res_valid), 32'd1);
    chk("bp_hold_data",  res_data,       held);
    chk("bp_first_data", held,           vecs[0].sum);
    res_ready = 1'b1;
    got = 0;
    t   = 0;
    while (got < 5 && t < 100) begin
      if (res_valid) begin
        chk($sformatf("bp_drain%0d", got), res_data, vecs[got].sum);
        got++;
      end
      @(negedge clk);
      t++;
    end
    chk("bp_drain_count", 32'(got), 32'd5);
    repeat (3) @(negedge clk);
    chk("bp_idle_busy",     32'(busy),     32'd0);
    chk("bp_idle_in_ready", 32'(in_ready), 32'd1);

    // Reset mid-RUN with two entries queued
    @(negedge clk);
    in_valid = 1'b1;
    in_a = vecs[0].a; in_b = vecs[0].b;
    @(negedge clk);
    in_a = vecs[2].a; in_b = vecs[2].b;
    @(negedge clk);
    in_a = vecs[3].a; in_b = vecs[3].b;
    @(negedge clk);
    in_valid = 1'b0;
    edges = 0;
    while (!add_enable && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    chk("rr_reached_run", 32'(add_enable), 32'd1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rr_enable_async", 32'(add_enable), 32'd0);
    chk("rr_valid_async",  32'(res_valid),  32'd0);
    chk("rr_busy_async",   32'(busy),       32'd0);
    chk("rr_sticky_clear", 32'(ovf_sticky), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    stale = 0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid || add_enable) stale++;
    end
    chk("rr_no_stale",  32'(stale),    32'd0);
    chk("rr_in_ready",  32'(in_ready), 32'd1);
    chk("rr_busy_idle", 32'(busy),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
